// File: rtl/any1_inst_align_queue_pkg.sv
// Shared types for the ANY1 instruction-alignment queue.
// Used by any1_inst_extract and any1_inst_align_queue.
package any1_inst_align_queue_pkg;

    localparam int LINE_BITS = 512;

    typedef logic [31:0] Instruction;

    // Encoding substituted for any instruction fetched from a misaligned ip.
    localparam Instruction NOP_INSN = 32'h3F3F3F3F;

    typedef struct packed {
        logic                 wr;
        logic [31:0]          ip;
    } sRedirect;

    typedef struct packed {
        logic [LINE_BITS-1:0] cacheline;
        logic [31:0]          ip;
        logic [31:0]          pip;
        logic [3:0]           rid;
        logic [1:0]           Stream;
        logic                 predict_taken;
    } sInstAlignIn;

    typedef struct packed {
        Instruction           ir;
        logic [31:0]          ip;
        logic [31:0]          pip;
        logic [3:0]           rid;
        logic [1:0]           Stream;
        logic                 predict_taken;
    } sInstAlignOut;

    typedef struct packed {
        sInstAlignOut         o;
        logic                 fault;
    } sAlignQEntry;

endpackage

// File: rtl/any1_inst_align_queue_extract.sv
// any1_inst_extract: pulls one 32-bit instruction out of a 512-bit cacheline.
// Purely combinational; shared with the dual-issue aligner.
module any1_inst_extract
    import any1_inst_align_queue_pkg::*;
(
    input  logic [LINE_BITS-1:0] cacheline_i,
    input  logic [5:0]           ofs_i,
    output Instruction           ir_o,
    output logic                 fault_o
);

    // An aligned offset is always a multiple of 4 and at most 60, so indexing
    // by word keeps the slice inside the line even for misaligned offsets
    // (whose result is replaced by NOP_INSN anyway).
    always_comb begin
        fault_o = (ofs_i[1:0] != 2'b00);
        ir_o    = cacheline_i[{ofs_i[5:2], 5'b00000} +: 32];
        if (fault_o) begin
            ir_o = NOP_INSN;
        end
    end

endmodule

// File: rtl/any1_inst_align_queue.sv
// any1_inst_align_queue: aligns fetched instructions and buffers them for decode.
// Optional same-cycle bypass when the queue is empty: define ANY1_ALIGN_BYPASS_EN.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; ready never depends on valid, and a presented head entry stays
// stable until it is consumed or flushed.
module any1_inst_align_queue
    import any1_inst_align_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH)
)(
    input  logic         clk_i,
    input  logic         rst_ni,
    input  sRedirect     redirect_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  sInstAlignIn  in_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output sInstAlignOut out_o,
    output logic         out_fault_o,
    output logic [PW:0]  count_o
);

    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    sAlignQEntry   mem_q [DEPTH];
    logic [PW-1:0] rd_q, wr_q;
    logic [PW:0]   count_q;

    Instruction    ext_ir;
    logic          ext_fault;
    sAlignQEntry   new_entry;
    logic          bypass;
    logic          push;
    logic          pop;

    // Only the write strobe of the redirect matters here.
    logic          unused_redirect_ip;
    assign unused_redirect_ip = ^redirect_i.ip;

    any1_inst_extract u_extract (
        .cacheline_i (in_i.cacheline),
        .ofs_i       (in_i.ip[5:0]),
        .ir_o        (ext_ir),
        .fault_o     (ext_fault)
    );

    // Build the queue entry for the incoming fetch.
    always_comb begin
        new_entry                 = '0;
        new_entry.o.ir            = ext_ir;
        new_entry.o.ip            = in_i.ip;
        new_entry.o.pip           = in_i.pip;
        new_entry.o.rid           = in_i.rid;
        new_entry.o.Stream        = in_i.Stream;
        new_entry.o.predict_taken = in_i.predict_taken;
        new_entry.fault           = ext_fault;
    end

    assign in_ready_o = rst_ni && (count_q != FULL_CNT) && !redirect_i.wr;

`ifdef ANY1_ALIGN_BYPASS_EN
    assign bypass = rst_ni && (count_q == '0) && in_valid_i && out_ready_i && !redirect_i.wr;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed instruction goes straight to decode and is never stored.
    assign push    = in_valid_i && in_ready_o && !bypass;
    assign pop     = (count_q != '0) && out_ready_i;
    assign count_o = count_q;

    // Present the head entry, or the live extraction when bypassing.
    always_comb begin
        out_o       = mem_q[rd_q].o;
        out_fault_o = mem_q[rd_q].fault;
        out_valid_o = (count_q != '0);
        if (bypass) begin
            out_o       = new_entry.o;
            out_fault_o = new_entry.fault;
            out_valid_o = 1'b1;
        end
    end

    // Queue state: reset beats flush, flush beats push/pop.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (redirect_i.wr) begin
            count_q <= '0;
            rd_q    <= wr_q;
        end else begin
            if (push) begin
                mem_q[wr_q] <= new_entry;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop) begin
                rd_q <= rd_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: doc/any1_inst_align_queue.md
Name: any1_inst_align_queue

Overview:
Instruction-alignment and buffering stage between the L1 I-cache fetch and decode.
- Accepts one sInstAlignIn per cycle, carrying a 512-bit cacheline plus ip/pip/rid/Stream/predict_taken.
- Extracts the 32-bit Instruction at ip[5:0] and enqueues it as an sInstAlignOut in a small FIFO.
- Decode drains the FIFO with a valid/ready handshake.
- A redirect (branch mispredict or exception) flushes all buffered instructions.

Parameters:
- DEPTH, 4, number of FIFO entries; must be a power of two, minimum 2.
- PW, $clog2(DEPTH), read/write pointer width.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_ni  input  1  reset; synchronous, active-low.
- redirect_i  input  sRedirect  flush request; only redirect_i.wr is used.
- in_valid_i  input  1  in_i is valid this cycle.
- in_ready_o  output  1  queue can accept in_i this cycle.
- in_i  input  sInstAlignIn  fetched cacheline and fetch metadata.
- out_valid_o  output  1  head entry is valid.
- out_ready_i  input  1  decode consumes the head entry this cycle.
- out_o  output  sInstAlignOut  head entry.
- out_fault_o  output  1  head entry has an alignment fault.
- count_o  output  PW+1  number of occupied entries.

Behaviour:
- Reset (rst_ni low at a clock edge):
  - count_o=0, rd/wr pointers=0, out_valid_o=0, out_fault_o=0, all entry storage cleared.
  - in_ready_o is forced 0 combinationally while rst_ni is low.
- in_ready_o = rst_ni && (count_o != DEPTH) && !redirect_i.wr, combinational.
  - A full queue does not accept input in the same cycle as a pop; it re-opens the cycle after the pop.
- Push when in_valid_i && in_ready_o. Pop when out_valid_o && out_ready_i.
- Extraction, combinational on in_i:
  - ofs = in_i.ip[5:0].
  - ir = in_i.cacheline[ofs*8 +: 32], little-endian byte order.
  - Stream, rid, ip, pip and predict_taken are copied unchanged.
- Alignment fault when in_i.ip[1:0] != 2'b00:
  - The entry stores ir=NOP_INSN and fault=1.
  - This is the only fault condition; ip/pip are still copied.
  - An aligned ip with ofs<=60 never crosses the line.
- Latency:
  - An instruction pushed at edge N is visible on out_o/out_valid_o after edge N (registered).
  - Minimum accept-to-consume is 1 cycle.
- out_o and out_fault_o come from the head entry.
  - They are held stable while out_valid_o && !out_ready_i.
  - out_valid_o = (count_o != 0).
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- Flush (redirect_i.wr=1 at an edge):
  - count_o←0, rd_ptr←wr_ptr.
  - Any push that cycle is dropped (in_ready_o is already 0).
  - Any pop that cycle is discarded.
  - out_valid_o=0 the next cycle.
  - Flush has priority over push and pop. Reset has priority over flush.
- Reset mid-operation discards all contents; no partial entries survive.
- count_o never exceeds DEPTH. Pop on empty and push on full are impossible by construction.

Optional Feature:
ANY1_ALIGN_BYPASS_EN
- Enabled: when count_o==0, in_valid_i, out_ready_i and !redirect_i.wr all hold:
  - The extracted instruction is presented on out_o the same cycle with out_valid_o=1.
  - It is not enqueued; count_o stays 0.
  - out_o, out_fault_o and out_valid_o become combinational from in_i in this case.
  - All other behaviour is unchanged.
- Disabled: outputs are purely registered, with the 1-cycle minimum latency above.

Decomposition:
- Shared package: sInstAlignIn, sInstAlignOut, sRedirect, Instruction, NOP_INSN.
  - Add typedef sAlignQEntry {sInstAlignOut o; logic fault;} to the package.
- Sub-module any1_inst_extract: purely combinational; cacheline+ip → ir and fault. It is reused by the future dual-issue aligner.
- FIFO control stays in the top module.

Test Plan:
- Extract, no bypass: ip=32'hFFFD0008, cacheline bytes 8..11 = 8'h04,8'h21,8'h30,8'h00 → next cycle out_o.ir=32'h00302104, out_fault_o=0, out_o.ip=32'hFFFD0008, count_o=1.
- Fill/full: DEPTH=4, out_ready_i=0, push 5 aligned lines → in_ready_o=0 after the 4th push, count_o=4, 5th held. Raise out_ready_i for 1 cycle → head popped, in_ready_o=1 the following cycle, 5th accepted.
- Misalign: ip=32'hFFFD0006 → out_o.ir=NOP_INSN (32'h3F3F3F3F), out_fault_o=1, out_o.ip=32'hFFFD0006.
- Flush: 3 entries queued, redirect_i.wr=1 with in_valid_i=1 → in_ready_o=0 that cycle, next cycle count_o=0, out_valid_o=0, dropped input never appears.
- Wrap plus simultaneous push/pop: stream 10 instructions with out_ready_i=1 and in_valid_i=1 continuously → count_o stays 1 (0 with bypass), outputs in order with ip incrementing by 4, pointers wrap twice.
- Sync reset mid-stream: 2 entries queued, rst_ni=0 for one edge → count_o=0, out_valid_o=0; in_ready_o=0 while rst_ni is low, 1 after.
